// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its sequencing front end.
// Opcodes are shared with the ALU instance and the test benches.
package alu_pkg;

   localparam int ALU_W = 4;

   localparam logic [2:0] OP_ADD     = 3'b000;
   localparam logic [2:0] OP_SUB     = 3'b001;
   localparam logic [2:0] OP_NOT     = 3'b010;
   localparam logic [2:0] OP_AND     = 3'b011;
   localparam logic [2:0] OP_OR      = 3'b100;
   localparam logic [2:0] OP_XOR     = 3'b101;
   localparam logic [2:0] OP_COMPARE = 3'b110;
   localparam logic [2:0] OP_NOP     = 3'b111;

   localparam logic [7:0] OPS_DONE_MAX = 8'd255;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } alu_seq_state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Command, ALU and response channels of alu_seq.
// slave is the alu_seq view; master is the driver/ALU-side view.
interface alu_seq_if #(
   parameter int AW = 2
) ();
   import alu_pkg::*;

   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [AW-1:0]    cmd_rd;
   logic [AW-1:0]    cmd_rs1;
   logic [AW-1:0]    cmd_rs2;
   logic             cmd_imm_en;
   logic [ALU_W-1:0] cmd_imm;

   logic [2:0]       alu_op;
   logic [ALU_W-1:0] alu_a;
   logic [ALU_W-1:0] alu_b;
   logic [ALU_W-1:0] alu_result;
   logic             alu_overflow;
   logic             alu_zero;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [ALU_W-1:0] rsp_data;
   logic             rsp_overflow;
   logic             rsp_zero;

   modport slave (
      input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_en, cmd_imm,
      output cmd_ready,
      output alu_op, alu_a, alu_b,
      input  alu_result, alu_overflow, alu_zero,
      output rsp_valid, rsp_data, rsp_overflow, rsp_zero,
      input  rsp_ready
   );

   modport master (
      output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_en, cmd_imm,
      input  cmd_ready,
      input  alu_op, alu_a, alu_b,
      output alu_result, alu_overflow, alu_zero,
      input  rsp_valid, rsp_data, rsp_overflow, rsp_zero,
      output rsp_ready
   );

endinterface

// File: rtl/alu_seq_regfile.sv
// NREG x ALU_W register file: one synchronous write port, three
// combinational read ports (two operands plus debug), synchronous reset.
module alu_seq_regfile
   import alu_pkg::*;
#(
   parameter int NREG = 4,
   parameter int AW   = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    wr_addr,
   input  logic [ALU_W-1:0] wr_data,
   input  logic [AW-1:0]    rs1_addr,
   input  logic [AW-1:0]    rs2_addr,
   input  logic [AW-1:0]    dbg_addr,
   output logic [ALU_W-1:0] rs1_data,
   output logic [ALU_W-1:0] rs2_data,
   output logic [ALU_W-1:0] dbg_data
);

   logic [ALU_W-1:0] regs_q [NREG];
   logic [ALU_W-1:0] regs_d [NREG];

   // Next register contents: only the addressed entry takes the write data.
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         regs_d[i] = (we && (wr_addr == AW'(i))) ? wr_data : regs_q[i];
      end
   end

   // Register storage with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= {ALU_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign rs1_data = regs_q[rs1_addr];
   assign rs2_data = regs_q[rs2_addr];
   assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_seq.sv
// Sequencing front end for the 4-bit ALU: accepts register-addressed
// commands, drives the ALU for one EXEC cycle and writes the result back.
module alu_seq
   import alu_pkg::*;
#(
   parameter int NREG = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   alu_seq_if.slave                bus,
   output logic                    ovf_sticky,
   output logic [7:0]              ops_done,
   input  logic [$clog2(NREG)-1:0] dbg_addr,
   output logic [ALU_W-1:0]        dbg_data
);

   localparam int AW = $clog2(NREG);

   alu_seq_state_t   state_q, state_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [2:0]       alu_op_q, alu_op_d;
   logic [ALU_W-1:0] alu_a_q, alu_a_d;
   logic [ALU_W-1:0] alu_b_q, alu_b_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [ALU_W-1:0] rsp_data_q, rsp_data_d;
   logic             rsp_overflow_q, rsp_overflow_d;
   logic             rsp_zero_q, rsp_zero_d;
   logic             ovf_sticky_q, ovf_sticky_d;
   logic [7:0]       ops_done_q, ops_done_d;

   logic             cmd_fire;
   logic             rsp_fire;
   logic             rf_we;
   logic [ALU_W-1:0] rs1_data;
   logic [ALU_W-1:0] rs2_data;

   assign cmd_fire = bus.cmd_valid & cmd_ready_q;
   assign rsp_fire = bus.rsp_ready & rsp_valid_q;
   assign rf_we    = (state_q == EXEC) && (alu_op_q != OP_NOP);

   // Operands are read at accept time; the file cannot change before EXEC,
   // so rd == rs1/rs2 naturally sees the pre-write value.
   alu_seq_regfile #(
      .NREG (NREG),
      .AW   (AW)
   ) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .we       (rf_we),
      .wr_addr  (rd_q),
      .wr_data  (bus.alu_result),
      .rs1_addr (bus.cmd_rs1),
      .rs2_addr (bus.cmd_rs2),
      .dbg_addr (dbg_addr),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .dbg_data (dbg_data)
   );

   // Next-state and datapath update for the IDLE/EXEC/RESP sequence.
   always_comb begin
      state_d        = state_q;
      alu_op_d       = alu_op_q;
      alu_a_d        = alu_a_q;
      alu_b_d        = alu_b_q;
      rd_d           = rd_q;
      rsp_data_d     = rsp_data_q;
      rsp_overflow_d = rsp_overflow_q;
      rsp_zero_d     = rsp_zero_q;
      ovf_sticky_d   = ovf_sticky_q;
      ops_done_d     = ops_done_q;

      case (state_q)
         IDLE: begin
            if (cmd_fire) begin
               state_d  = EXEC;
               alu_op_d = bus.cmd_op;
               alu_a_d  = rs1_data;
               alu_b_d  = bus.cmd_imm_en ? bus.cmd_imm : rs2_data;
               rd_d     = bus.cmd_rd;
            end else begin
               state_d  = IDLE;
            end
         end
         EXEC: begin
            state_d        = RESP;
            rsp_data_d     = bus.alu_result;
            rsp_overflow_d = bus.alu_overflow;
            rsp_zero_d     = bus.alu_zero;
            ovf_sticky_d   = ovf_sticky_q | bus.alu_overflow;
            ops_done_d     = (ops_done_q == OPS_DONE_MAX) ? ops_done_q : ops_done_q + 8'd1;
         end
         RESP: begin
            if (rsp_fire) begin
               state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      cmd_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP);
   end

   // State and output registers; reset overrides any handshake in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         cmd_ready_q    <= 1'b1;
         rsp_valid_q    <= 1'b0;
         alu_op_q       <= 3'b000;
         alu_a_q        <= {ALU_W{1'b0}};
         alu_b_q        <= {ALU_W{1'b0}};
         rd_q           <= {AW{1'b0}};
         rsp_data_q     <= {ALU_W{1'b0}};
         rsp_overflow_q <= 1'b0;
         rsp_zero_q     <= 1'b0;
         ovf_sticky_q   <= 1'b0;
         ops_done_q     <= 8'd0;
      end else begin
         state_q        <= state_d;
         cmd_ready_q    <= cmd_ready_d;
         rsp_valid_q    <= rsp_valid_d;
         alu_op_q       <= alu_op_d;
         alu_a_q        <= alu_a_d;
         alu_b_q        <= alu_b_d;
         rd_q           <= rd_d;
         rsp_data_q     <= rsp_data_d;
         rsp_overflow_q <= rsp_overflow_d;
         rsp_zero_q     <= rsp_zero_d;
         ovf_sticky_q   <= ovf_sticky_d;
         ops_done_q     <= ops_done_d;
      end
   end

   assign bus.cmd_ready    = cmd_ready_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_data     = rsp_data_q;
   assign bus.rsp_overflow = rsp_overflow_q;
   assign bus.rsp_zero     = rsp_zero_q;
   assign bus.alu_op       = alu_op_q;
   assign bus.alu_a        = alu_a_q;
   assign bus.alu_b        = alu_b_q;
   assign ovf_sticky       = ovf_sticky_q;
   assign ops_done         = ops_done_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequencing front end for the team's 4-bit combinational ALU. Accepts register-addressed ALU commands over a valid/ready handshake and holds a small 4-bit register file. Drives the ALU's `op`/`A`/`B` inputs and writes `alu_result` back into the register file. Returns result and flags on a valid/ready response channel. It is the initiator side of the ALU interface and sits between the npc decode stage (or a test driver) and the ALU instance.

## Interface
Parameters:
- `NREG`, 4: number of 4-bit registers; power of two, ≥2; address width `AW = $clog2(NREG)`.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_op`  in  3  ALU opcode.
- `cmd_rd`, `cmd_rs1`, `cmd_rs2`  in  AW each  destination and source register indices.
- `cmd_imm_en`  in  1  when 1, operand B is `cmd_imm` instead of `R[rs2]`.
- `cmd_imm`  in  4  two's-complement immediate.
- `alu_op`  out  3  to ALU `op`.
- `alu_a`, `alu_b`  out  4 each  to ALU `A` and `B`.
- `alu_result`  in  4  from ALU.
- `alu_overflow`, `alu_zero`  in  1 each  from ALU.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_data`  out  4  captured result.
- `rsp_overflow`, `rsp_zero`  out  1 each  captured flags.
- `ovf_sticky`  out  1  set by any overflow since reset.
- `ops_done`  out  8  completed-command count, saturates at 255.
- `dbg_addr`  in  AW  register-file debug read index.
- `dbg_data`  out  4  `R[dbg_addr]`, combinational.

## Operation
- Opcodes: ADD 000, SUB 001, NOT 010, AND 011, OR 100, XOR 101, COMPARE 110 (signed A<B → 1, else 0), NOP 111.
- FSM states: IDLE, EXEC, RESP.
- IDLE: `cmd_ready=1`. On `cmd_valid&cmd_ready`, latch op/rd/rs1/rs2/imm_en/imm and go to EXEC.
- EXEC: `cmd_ready=0`. Drive `alu_op` = latched op, `alu_a` = `R[rs1]`, `alu_b` = imm_en ? imm : `R[rs2]`.
- End of EXEC:
  - Capture `alu_result`, `alu_overflow` and `alu_zero` into the rsp registers.
  - Write `R[rd] <= alu_result` unless op=NOP.
  - OR `alu_overflow` into `ovf_sticky`.
  - Increment `ops_done` (saturating).
  - Go to RESP.
- NOP: no register write. Response carries whatever the ALU returns (ALU default gives data 0, zero 1, overflow 0).
- Overflowed ADD/SUB writes the ALU's result (0) to `rd`; no special handling here.
- RESP: `rsp_valid=1`, rsp fields stable. On `rsp_ready`, return to IDLE. Commands are not accepted in RESP.
- Outside EXEC, `alu_op`/`alu_a`/`alu_b` hold their last driven values. Only EXEC-cycle values are meaningful.
- rd equal to rs1/rs2: operands read the pre-write value.
- `R[0]` is an ordinary writable register.

## Timing
- Reset values:
  - FSM = IDLE, all `R[i]=0`.
  - `cmd_ready=1`, `rsp_valid=0`.
  - `rsp_data=0`, `rsp_overflow=0`, `rsp_zero=0`.
  - `ovf_sticky=0`, `ops_done=0`.
  - `alu_op=0`, `alu_a=0`, `alu_b=0`.
- Command accepted at edge N: EXEC during cycle N+1; write-back and capture at edge N+2; `rsp_valid=1` from cycle N+2.
- With `rsp_ready` held high, the response retires at edge N+3 and `cmd_ready=1` in cycle N+3. Peak throughput is 1 command per 3 cycles.
- `rsp_valid`, once high, stays high with stable data until handshake (or `rst`).
- `rst` in any state:
  - Takes effect at the next edge and wins over every handshake in that cycle.
  - An in-flight command is dropped with no write-back.
  - A pending response is discarded.
- `dbg_data` reflects a write-back in the cycle after the write edge.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams (`OP_ADD`…`OP_NOP`),
  - `ALU_W=4`,
  - FSM state enum `alu_seq_state_t`.
  - The ALU instance and tests import the same opcodes.
- Sub-module `alu_seq_regfile`: NREG×4 registers, one sync write port, three combinational read ports (rs1, rs2, dbg), sync reset to 0.
- The ALU is not instantiated inside. The top level wires `alu_*` ports to it. The bench instantiates the real ALU.

## Test plan
- Reset, then OR rd=1 rs1=0 imm=5 → `rsp_data=5`, `rsp_zero=0`, `dbg R1=5`, `rsp_valid` exactly 2 cycles after accept.
- With R1=5: ADD rd=2 rs1=1 imm=3 (5+3 overflows) → `rsp_data=0`, `rsp_overflow=1`, `rsp_zero=1`, R2=0, `ovf_sticky=1` and stays 1 after later non-overflowing ops.
- With R1=5: COMPARE rs1=1 imm=4'b1110 (−2) → `rsp_data=0`, `rsp_zero=1`. COMPARE rs1=1 imm=7 → `rsp_data=1`.
- Backpressure: hold `rsp_ready=0` for 5 cycles with `cmd_valid=1` → `cmd_ready=0`, `rsp_*` stable, no second command taken. Release → exactly one retire, then next accept.
- Assert `rst` during EXEC of SUB rd=3 → R3 stays 0, `rsp_valid=0`, `ops_done=0`, `cmd_ready=1` next cycle.
- NOP rd=1 after R1=5 → R1 still 5, `rsp_data=0`, `rsp_zero=1`. 260 back-to-back ops → `ops_done=255`.
